// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - operand/issue and writeback controller for the clocked alu32
// Holds the register file, issues one command at a time and writes the ALU result back.
module alu_issue_ctrl #(
  parameter int DATA_W  = 32,
  parameter int NREG    = 8,
  parameter int AW      = $clog2(NREG),
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_sel,
  input  logic [AW-1:0]     cmd_rs1,
  input  logic [AW-1:0]     cmd_rs2,
  input  logic [AW-1:0]     cmd_rd,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_overflow,
  output logic              done,
  output logic              ovf_sticky,
  input  logic              ovf_clr,
  output logic              busy
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [AW:0] NREG_V = NREG[AW:0];

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     rd_q;
  logic [DATA_W-1:0] regs [NREG];

  // Addresses past NREG exist only when NREG is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] addr);
    return {1'b0, addr} < NREG_V;
  endfunction

  function automatic logic [DATA_W-1:0] read_reg(input logic [AW-1:0] addr);
    return in_range(addr) ? regs[addr] : '0;
  endfunction

  always_comb begin
    rd_data   = read_reg(rd_addr);
    cmd_ready = (state == IDLE) && !rst;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_q       <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      done       <= 1'b0;
      ovf_sticky <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      if (ovf_clr) ovf_sticky <= 1'b0;
      if (wr_en && in_range(wr_addr)) regs[wr_addr] <= wr_data;
      // Writeback and overflow set come later so they override host write and clear.
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_a   <= read_reg(cmd_rs1);
            alu_b   <= read_reg(cmd_rs2);
            alu_sel <= cmd_sel;
            rd_q    <= cmd_rd;
            cnt     <= CW'(ALU_LAT - 1);
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) state <= WB;
          else           cnt   <= cnt - 1'b1;
        end
        WB: begin
          if (in_range(rd_q)) regs[rd_q] <= alu_out;
          if (alu_overflow) ovf_sticky <= 1'b1;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized self-checking bench for alu_issue_ctrl
// Uses an adder ALU stub with one registered stage and a register-array reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_sel;
  logic [2:0]  cmd_rs1, cmd_rs2, cmd_rd;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_overflow;
  logic        done;
  logic        ovf_sticky;
  logic        ovf_clr;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model [8];
  bit          sticky;

  alu_issue_ctrl #(.DATA_W(32), .NREG(8), .AW(3), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .done(done), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU stub: one registered stage, out = a + b, signed overflow flag.
  always_ff @(posedge clk) begin
    alu_out      <= alu_a + alu_b;
    alu_overflow <= (alu_a[31] == alu_b[31]) && ((alu_a + alu_b) >> 31 != {31'b0, alu_a[31]});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input int idx);
    rd_addr = 3'(idx);
    #1;
    check(tag, rd_data, model[idx]);
  endtask

  task automatic scan_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      check_reg(tag, i);
      tick();
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = '0;
    sticky = 1'b0;
  endtask

  task automatic host_write(input int addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = 3'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
    model[addr] = data;
  endtask

  function automatic bit signed_ovf(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // One command with optional host write during EXEC (to rs1), host write and ovf_clr on the WB edge.
  task automatic run_cmd(input int rs1, input int rs2, input int rd, input logic [3:0] sel,
                         input bit exec_wr, input bit wb_wr, input int wb_addr,
                         input logic [31:0] wb_data, input bit wb_clr);
    logic [31:0] a, b;
    a = model[rs1];
    b = model[rs2];
    check("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rs1 = 3'(rs1); cmd_rs2 = 3'(rs2); cmd_rd = 3'(rd); cmd_sel = sel;
    tick();
    cmd_valid = 1'b0;
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_sel", alu_sel, sel);
    check("ready_exec", cmd_ready, 0);
    check("busy_exec", busy, 1);
    check("done_exec", done, 0);
    if (exec_wr) begin
      wr_en = 1'b1; wr_addr = 3'(rs1); wr_data = ~a;
    end
    tick();
    wr_en = 1'b0;
    if (exec_wr) model[rs1] = ~a;
    check("alu_a_hold", alu_a, a);
    check("ready_wb", cmd_ready, 0);
    check("done_wb", done, 0);
    if (wb_wr) begin
      wr_en = 1'b1; wr_addr = 3'(wb_addr); wr_data = wb_data;
    end
    ovf_clr = wb_clr;
    tick();
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    if (wb_wr) model[wb_addr] = wb_data;
    model[rd] = a + b;
    sticky = (sticky && !wb_clr) || signed_ovf(a, b);
    check("done_pulse", done, 1);
    check("ready_done", cmd_ready, 1);
    check("busy_done", busy, 0);
    check("ovf_sticky", ovf_sticky, sticky);
    check_reg("wb_reg", rd);
    if (wb_wr) check_reg("wb_host_reg", wb_addr);
    tick();
    check("done_off", done, 0);
  endtask

  initial begin
    int acc_cyc [2];
    int n_acc, n_done;
    logic [31:0] v;

    rst = 1'b1; cmd_valid = 1'b0; cmd_sel = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; ovf_clr = 1'b0;
    model_reset();
    tick(); tick();
    check("ready_in_rst", cmd_ready, 0);
    rst = 1'b0;
    tick();
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_ovf", ovf_sticky, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_busy", busy, 0);
    scan_regs("rst_reg");

    // Basic op
    host_write(1, 1);
    host_write(2, 1);
    run_cmd(1, 2, 3, 4'd0, 0, 0, 0, 0, 0);
    rd_addr = 3'd3; #1;
    check("basic_r3", rd_data, 32'd2);

    // Overflow and sticky behaviour
    host_write(1, 32'h7FFF_FFFF);
    host_write(2, 32'h1);
    run_cmd(1, 2, 4, 4'd1, 0, 0, 0, 0, 0);
    rd_addr = 3'd4; #1;
    check("ovf_r4", rd_data, 32'h8000_0000);
    check("ovf_set", ovf_sticky, 1);
    host_write(5, 32'd3);
    run_cmd(5, 5, 6, 4'd2, 0, 0, 0, 0, 0);
    check("ovf_hold", ovf_sticky, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    sticky = 1'b0;
    check("ovf_cleared", ovf_sticky, 0);

    // Chaining and writeback-vs-host collision
    host_write(1, 32'd5);
    run_cmd(1, 1, 1, 4'd0, 0, 0, 0, 0, 0);
    rd_addr = 3'd1; #1;
    check("chain_r1", rd_data, 32'd10);
    run_cmd(1, 1, 1, 4'd0, 0, 1, 1, 32'd7, 0);
    rd_addr = 3'd1; #1;
    check("collide_r1", rd_data, 32'd20);

    // Back-to-back with cmd_valid held high
    host_write(2, 32'd3);
    cmd_valid = 1'b1; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_rd = 3'd6; cmd_sel = 4'd3;
    n_acc = 0; n_done = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cmd_valid && cmd_ready && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      tick();
      if (done) n_done++;
      if (n_acc == 1) begin
        cmd_rs1 = 3'd6; cmd_rs2 = 3'd6; cmd_rd = 3'd7;
      end
      if (n_acc == 2) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    check("b2b_accepts", n_acc, 2);
    check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 3);
    check("b2b_dones", n_done, 2);
    model[6] = model[1] + model[2];
    model[7] = model[6] + model[6];
    check_reg("b2b_r6", 6);
    check_reg("b2b_r7", 7);
    tick();

    // Randomized commands with interleaved host writes and ovf_clr
    for (int n = 0; n < 40; n++) begin
      v = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFF0 + 32'($urandom_range(0, 31)) : $urandom;
      host_write($urandom_range(0, 7), v);
      run_cmd($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
              bit'($urandom_range(0, 1)));
    end
    scan_regs("rand_reg");

    // Reset mid-op
    host_write(1, 32'd3);
    host_write(2, 32'd4);
    cmd_valid = 1'b1; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_rd = 3'd5; cmd_sel = 4'd9;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ready", cmd_ready, 0);
    tick();
    rst = 1'b0;
    model_reset();
    check("midrst_done0", done, 0);
    tick();
    check("midrst_done1", done, 0);
    check("midrst_ready_after", cmd_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_alu_a", alu_a, 0);
    check("midrst_ovf", ovf_sticky, 0);
    tick();
    check("midrst_done2", done, 0);
    scan_regs("midrst_reg");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
